// File: rtl/sd_adc_rx.sv
// sd_adc_rx: 1-bit sigma-delta ADC receiver. Synchronizes the external
// comparator, closes the first-order loop through fb_out, and decimates the
// bitstream with a 2nd-order CIC into unsigned OUT_W-bit samples. Samples
// leave through a one-entry valid/ready register.
// Build option: define SD_ADC_CLIP_EN to add the 'clip' output flag.
//
// state    | meaning
// ---------+------------------------------------------------------
// S_WARMUP | first two CIC ticks after reset; comb delays settling
// S_RUN    | every tick yields an output sample
module sd_adc_rx #(
  parameter int DECIM = 256,
  parameter int OUT_W = 16
) (
  input  logic             clk27,
  input  logic             n_rst,
  input  logic             comp_in,
  output logic             fb_out,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid,
  input  logic             sample_ready,
`ifdef SD_ADC_CLIP_EN
  output logic             clip,
`endif
  output logic             overrun
);

  localparam int LOG2_D = $clog2(DECIM);
  localparam int W      = 2*LOG2_D + 1;
  localparam logic [LOG2_D-1:0] DCNT_LAST = LOG2_D'(DECIM - 1);

  typedef enum logic [0:0] {
    S_WARMUP = 1'b0,
    S_RUN    = 1'b1
  } state_t;

  state_t            state_q;
  logic [1:0]        warm_q;

  logic              sync1_q, sync1_d;
  logic              comp_s_q, comp_s_d;
  logic              fb_q, fb_d;
  logic [W-1:0]      i1_q, i1_d;
  logic [W-1:0]      i2_q, i2_d;
  logic [LOG2_D-1:0] dcnt_q, dcnt_d;
  logic              tick;

  // Comb stage A (on tick) and stage B (one clock later) are split so each
  // clock only carries one wide subtraction.
  logic [W-1:0]      d1_q, d1_d;
  logic [W-1:0]      c1_q, c1_d;
  logic [W-1:0]      d2_q, d2_d;
  logic [W-1:0]      y_q, y_d;
  logic              tick_a_q, tick_a_d;
  logic              a_vld_q, a_vld_d;
  logic              b_vld_q, b_vld_d;

  logic              y_over;
  logic [W-2:0]      y_sat;
  logic [OUT_W-1:0]  res_q, res_d;
  logic              res_vld_q, res_vld_d;

  logic              xfer;
  logic [OUT_W-1:0]  sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              overrun_q, overrun_d;
`ifdef SD_ADC_CLIP_EN
  logic              res_clip_q, res_clip_d;
  logic              clip_q, clip_d;
`endif

  // Decimation tick: last count of each DECIM-clock frame
  always_comb begin
    tick = (dcnt_q == DCNT_LAST);
  end

  // Warm-up sequencing: discard two ticks, then run
  always_ff @(posedge clk27) begin
    if (!n_rst) begin
      state_q <= S_WARMUP;
      warm_q  <= 2'd0;
    end else if (tick) begin
      case (state_q)
        S_WARMUP: begin
          warm_q <= warm_q + 2'd1;
          if (warm_q == 2'd1) state_q <= S_RUN;
        end
        default: ;
      endcase
    end
  end

  // Next values for loop, integrators, combs, scaling and output register
  always_comb begin
    sync1_d  = comp_in;
    comp_s_d = sync1_q;
    fb_d     = comp_s_q;

    i1_d   = i1_q + {{(W-1){1'b0}}, comp_s_q};
    i2_d   = i2_q + i1_q;
    dcnt_d = dcnt_q + LOG2_D'(1);

    c1_d     = c1_q;
    d1_d     = d1_q;
    tick_a_d = tick;
    a_vld_d  = tick && (state_q == S_RUN);
    if (tick) begin
      c1_d = i2_q - d1_q;
      d1_d = i2_q;
    end

    y_d     = y_q;
    d2_d    = d2_q;
    b_vld_d = a_vld_q;
    if (tick_a_q) begin
      y_d  = c1_q - d2_q;
      d2_d = c1_q;
    end

    // Clamp to 2^(W-1)-1; the top bit of y set means y exceeds that bound.
    y_over    = y_q[W-1];
    y_sat     = y_over ? {(W-1){1'b1}} : y_q[W-2:0];
    res_d     = res_q;
    res_vld_d = b_vld_q;
`ifdef SD_ADC_CLIP_EN
    res_clip_d = res_clip_q;
`endif
    if (b_vld_q) begin
      res_d = y_sat[W-2 -: OUT_W];
`ifdef SD_ADC_CLIP_EN
      res_clip_d = y_over;
`endif
    end

    xfer           = sample_valid_q & sample_ready;
    sample_d       = sample_q;
    sample_valid_d = sample_valid_q & ~xfer;
    overrun_d      = 1'b0;
`ifdef SD_ADC_CLIP_EN
    clip_d = clip_q;
`endif
    if (res_vld_q) begin
      sample_d       = res_q;
      sample_valid_d = 1'b1;
      overrun_d      = sample_valid_q & ~sample_ready;
`ifdef SD_ADC_CLIP_EN
      clip_d = res_clip_q;
`endif
    end
  end

  // Datapath registers with synchronous active-low reset
  always_ff @(posedge clk27) begin
    if (!n_rst) begin
      sync1_q        <= 1'b0;
      comp_s_q       <= 1'b0;
      fb_q           <= 1'b0;
      i1_q           <= '0;
      i2_q           <= '0;
      dcnt_q         <= '0;
      d1_q           <= '0;
      c1_q           <= '0;
      d2_q           <= '0;
      y_q            <= '0;
      tick_a_q       <= 1'b0;
      a_vld_q        <= 1'b0;
      b_vld_q        <= 1'b0;
      res_q          <= '0;
      res_vld_q      <= 1'b0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef SD_ADC_CLIP_EN
      res_clip_q     <= 1'b0;
      clip_q         <= 1'b0;
`endif
    end else begin
      sync1_q        <= sync1_d;
      comp_s_q       <= comp_s_d;
      fb_q           <= fb_d;
      i1_q           <= i1_d;
      i2_q           <= i2_d;
      dcnt_q         <= dcnt_d;
      d1_q           <= d1_d;
      c1_q           <= c1_d;
      d2_q           <= d2_d;
      y_q            <= y_d;
      tick_a_q       <= tick_a_d;
      a_vld_q        <= a_vld_d;
      b_vld_q        <= b_vld_d;
      res_q          <= res_d;
      res_vld_q      <= res_vld_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
`ifdef SD_ADC_CLIP_EN
      res_clip_q     <= res_clip_d;
      clip_q         <= clip_d;
`endif
    end
  end

  assign fb_out       = fb_q;
  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
`ifdef SD_ADC_CLIP_EN
  assign clip         = clip_q;
`endif

endmodule

// File: tb/tb_sd_adc_rx.sv
// Self-checking bench for sd_adc_rx (DECIM=256, OUT_W=16).
module tb_sd_adc_rx;

  localparam int DECIM     = 256;
  localparam int OUT_W     = 16;
  localparam int FIRST_LAT = 3*DECIM + 3;

  logic             clk27 = 1'b0;
  logic             n_rst = 1'b0;
  logic             comp_in = 1'b0;
  logic             sample_ready = 1'b0;
  logic             fb_out;
  logic [OUT_W-1:0] sample;
  logic             sample_valid;
  logic             overrun;
`ifdef SD_ADC_CLIP_EN
  logic             clip;
`endif

  sd_adc_rx #(.DECIM(DECIM), .OUT_W(OUT_W)) dut (
    .clk27        (clk27),
    .n_rst        (n_rst),
    .comp_in      (comp_in),
    .fb_out       (fb_out),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
`ifdef SD_ADC_CLIP_EN
    .clip         (clip),
`endif
    .overrun      (overrun)
  );

  always #5 clk27 = ~clk27;

  typedef struct {
    logic [OUT_W-1:0] lo;
    logic [OUT_W-1:0] hi;
    logic             clip_exp;
    logic             dont_care;
  } exp_t;

  typedef struct {
    int               mode;     // 0: comp_in=0, 1: comp_in=1, 2: toggling
    int               n_samp;
    logic [OUT_W-1:0] lo;
    logic [OUT_W-1:0] hi;
    logic             clip_exp;
    logic             fb_chk;
    logic             fb_exp;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   n_overrun = 0;
  logic toggle_en = 1'b0;
  exp_t sb_q[$];

  int   e;
  int   last_e;
  int   got;
  logic prev_valid;
  logic [OUT_W-1:0] held;
  logic stable_ok;
  logic valid_ok;
  logic ovr_place_ok;
  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input logic [31:0] act,
                             input logic [31:0] lo, input logic [31:0] hi);
    checks++;
    if ((act < lo) || (act > hi) || $isunknown(act)) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h..%0h", name, act, lo, hi);
    end
  endtask

  // One clock: score a transfer about to happen, step, then sample outputs.
  task automatic tick();
    exp_t x;
    if (sample_valid && sample_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got sample %0h, required no transfer", sample);
      end else begin
        x = sb_q.pop_front();
        if (!x.dont_care) begin
          check_range("sb_sample", 32'(sample), 32'(x.lo), 32'(x.hi));
`ifdef SD_ADC_CLIP_EN
          check("sb_clip", 32'(clip), 32'(x.clip_exp));
`endif
        end
      end
    end
    @(posedge clk27);
    #2;
    if (overrun) n_overrun++;
    if (toggle_en) comp_in = ~comp_in;
  endtask

  task automatic do_reset(input int cycles);
    n_rst        = 1'b0;
    sample_ready = 1'b0;
    sb_q.delete();
    repeat (cycles) tick();
    n_rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1, 4, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{0, 4, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2, 4, 16'h7FFF, 16'h8001, 1'b0, 1'b0, 1'b0};

    // Reset state
    comp_in = 1'b1;
    do_reset(2);
    check("rst_valid",   32'(sample_valid), 32'd0);
    check("rst_sample",  32'(sample),       32'd0);
    check("rst_fb",      32'(fb_out),       32'd0);
    check("rst_overrun", 32'(overrun),      32'd0);
`ifdef SD_ADC_CLIP_EN
    check("rst_clip",    32'(clip),         32'd0);
`endif

    // Table-driven steady streams with ready held high
    for (int v = 0; v < 3; v++) begin
      toggle_en = 1'b0;
      comp_in   = (vecs[v].mode == 1);
      do_reset(2);
      sample_ready = 1'b1;
      if (vecs[v].mode == 2) toggle_en = 1'b1;
      for (int k = 0; k < vecs[v].n_samp; k++)
        sb_q.push_back('{vecs[v].lo, vecs[v].hi, vecs[v].clip_exp, 1'b0});
      e = 0; last_e = 0; got = 0; prev_valid = 1'b0;
      while (sb_q.size() > 0 && e < FIRST_LAT + (vecs[v].n_samp + 1)*DECIM) begin
        tick();
        e++;
        if (vecs[v].fb_chk && e == 2) check("fb_cycle2", 32'(fb_out), 32'd0);
        if (vecs[v].fb_chk && e == 3) check("fb_cycle3", 32'(fb_out), 32'(vecs[v].fb_exp));
        if (sample_valid && !prev_valid) begin
          if (got == 0) check("first_valid_lat", e, FIRST_LAT);
          else          check("valid_period", e - last_e, DECIM);
          last_e = e;
          got++;
        end
        prev_valid = sample_valid;
      end
      check("sb_drained", sb_q.size(), 32'd0);
      check("ovr_none", n_overrun, 32'd0);
      if (vecs[v].fb_chk) check("fb_end", 32'(fb_out), 32'(vecs[v].fb_exp));
    end
    toggle_en = 1'b0;

    // Held sample, 600 clocks of backpressure, then ready raised in a load cycle
    comp_in = 1'b1;
    do_reset(2);
    e = 0;
    while (!sample_valid && e < 2*FIRST_LAT) begin
      tick();
      e++;
    end
    check("hold_first_lat", e, FIRST_LAT);
    check("hold_first_val", 32'(sample), 32'hFFFF);
    comp_in = 1'b0;
    n_overrun = 0;
    held = sample; stable_ok = 1'b1; valid_ok = 1'b1; ovr_place_ok = 1'b1;
    for (int c = 0; c < 600; c++) begin
      tick();
      e++;
      if (((e - FIRST_LAT) % DECIM) == 0) held = sample;
      else begin
        if (sample !== held) stable_ok = 1'b0;
        if (overrun) ovr_place_ok = 1'b0;
      end
      if (!sample_valid) valid_ok = 1'b0;
    end
    check("hold_stable",    32'(stable_ok),    32'd1);
    check("hold_valid",     32'(valid_ok),     32'd1);
    check("ovr_only_load",  32'(ovr_place_ok), 32'd1);
    check("ovr_count",      n_overrun,         32'd2);
    while (e < 6*DECIM + 2) begin
      tick();
      e++;
    end
    sb_q.push_back('{16'h0000, 16'hFFFF, 1'b0, 1'b1});
    sb_q.push_back('{16'h0000, 16'h0000, 1'b0, 1'b0});
    sample_ready = 1'b1;
    tick();
    e++;
    check("ldx_valid",   32'(sample_valid), 32'd1);
    check("ldx_overrun", 32'(overrun),      32'd0);
    check("ldx_sample",  32'(sample),       32'h0000);
    check("ldx_ovr_cnt", n_overrun,         32'd2);
    tick();
    e++;
    check("xfer_drop",   32'(sample_valid), 32'd0);
    check("xfer_sb",     sb_q.size(),       32'd0);

    // Reset for one clock while a sample is held
    comp_in = 1'b1;
    do_reset(2);
    e = 0;
    while (!sample_valid && e < 2*FIRST_LAT) begin
      tick();
      e++;
    end
    repeat (5) tick();
    check("pre_rst_held", 32'(sample_valid), 32'd1);
    n_overrun = 0;
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    check("mrst_valid",   32'(sample_valid), 32'd0);
    check("mrst_sample",  32'(sample),       32'd0);
    check("mrst_fb",      32'(fb_out),       32'd0);
    check("mrst_overrun", 32'(overrun),      32'd0);
`ifdef SD_ADC_CLIP_EN
    check("mrst_clip",    32'(clip),         32'd0);
`endif
    e = 0;
    while (!sample_valid && e < 2*FIRST_LAT) begin
      tick();
      e++;
    end
    check("mrst_lat",     e,                 FIRST_LAT);
    check("mrst_value",   32'(sample),       32'hFFFF);
`ifdef SD_ADC_CLIP_EN
    check("mrst_clipset", 32'(clip),         32'd1);
`endif
    check("mrst_ovr",     n_overrun,         32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
